traffic_light_monitor: RTL and testbench

Passive checker that reads the 3-bit one-hot traffic-light output (RED=3'b100, GREEN=3'b010, YELLOW=3'b001) from the signal controller. It decodes the current phase, measures per-phase dwell in clock cycles, counts completed GREEN→YELLOW→RED cycles, and flags illegal codes, out-of-order phases and dwell-limit violations. It sits beside the controller on the same clock, for use in silicon self-check and in testbenches.

---
 rtl/traffic_light_monitor_if.sv | 30 +++
 rtl/traffic_light_monitor.sv | 189 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - light code from the controller and monitor status outputs
// master drives the light code, slave is the monitor that reports phase, dwell and errors.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       light;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] last_dwell;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;
  logic             err_illegal;
  logic             err_sequence;
  logic             err_dwell;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output light,
    input  phase, phase_valid, dwell, last_dwell, cycle_done, cycle_count,
    input  err_illegal, err_sequence, err_dwell, err_pulse, err_count
  );

  modport slave (
    input  light,
    output phase, phase_valid, dwell, last_dwell, cycle_done, cycle_count,
    output err_illegal, err_sequence, err_dwell, err_pulse, err_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker for a one-hot GREEN/YELLOW/RED light sequence
// Tracks phase and dwell, counts complete G->Y->R->G cycles, flags illegal codes, order and dwell errors.
module traffic_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 254
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [1:0]       PH_G  = 2'd0;
  localparam logic [1:0]       PH_Y  = 2'd1;
  localparam logic [1:0]       PH_R  = 2'd2;
  localparam logic [1:0]       PH_X  = 2'd3;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DWELL);

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] ccount_q, ccount_d;
  logic [CNT_W-1:0] ecount_q, ecount_d;
  logic [1:0]       chain_q, chain_d;
  logic             partial_q, partial_d;
  logic             from_track_q, from_track_d;
  logic             done_q, done_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic             dw_q, dw_d;
  logic             pulse_q, pulse_d;

  logic             code_ok;
  logic [1:0]       code_ph;
  logic [1:0]       succ_ph;
  logic             ev_ill, ev_seq, ev_dwell, ev_any;

  always_comb begin
    code_ok = 1'b1;
    code_ph = PH_X;
    case (mon.light)
      3'b010:  code_ph = PH_G;
      3'b001:  code_ph = PH_Y;
      3'b100:  code_ph = PH_R;
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (phase_q)
      PH_G:    succ_ph = PH_Y;
      PH_Y:    succ_ph = PH_R;
      PH_R:    succ_ph = PH_G;
      default: succ_ph = PH_X;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      phase_q      <= PH_X;
      dwell_q      <= '0;
      last_q       <= '0;
      ccount_q     <= '0;
      ecount_q     <= '0;
      chain_q      <= 2'd0;
      partial_q    <= 1'b0;
      from_track_q <= 1'b0;
      done_q       <= 1'b0;
      ill_q        <= 1'b0;
      seq_q        <= 1'b0;
      dw_q         <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      last_q       <= last_d;
      ccount_q     <= ccount_d;
      ecount_q     <= ecount_d;
      chain_q      <= chain_d;
      partial_q    <= partial_d;
      from_track_q <= from_track_d;
      done_q       <= done_d;
      ill_q        <= ill_d;
      seq_q        <= seq_d;
      dw_q         <= dw_d;
      pulse_q      <= pulse_d;
    end
  end

  // Next-state and event logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    last_d       = last_q;
    ccount_d     = ccount_q;
    chain_d      = chain_q;
    partial_d    = partial_q;
    from_track_d = 1'b0;
    done_d       = 1'b0;
    ev_ill       = 1'b0;
    ev_seq       = 1'b0;
    ev_dwell     = 1'b0;

    case (state_q)
      SYNC: begin
        if (code_ok) begin
          state_d   = TRACK;
          phase_d   = code_ph;
          dwell_d   = ONE;
          partial_d = 1'b1;
          chain_d   = 2'd0;
        end else begin
          ev_ill = from_track_q;
        end
      end
      TRACK: begin
        if (!code_ok) begin
          ev_ill       = 1'b1;
          state_d      = SYNC;
          phase_d      = PH_X;
          dwell_d      = '0;
          chain_d      = 2'd0;
          from_track_d = 1'b1;
        end else if (code_ph == phase_q) begin
          if (dwell_q != SAT) dwell_d = dwell_q + ONE;
          // Dwell only climbs by one, so this fires once per phase.
          if (dwell_q == MAX_C) ev_dwell = 1'b1;
        end else if (code_ph == succ_ph) begin
          if (!partial_q && (dwell_q < MIN_C)) ev_dwell = 1'b1;
          last_d    = dwell_q;
          dwell_d   = ONE;
          phase_d   = code_ph;
          partial_d = 1'b0;
          case (code_ph)
            PH_Y:    chain_d = 2'd1;
            PH_R:    chain_d = (chain_q == 2'd1) ? 2'd2 : 2'd0;
            default: begin
              if (chain_q == 2'd2) begin
                done_d   = 1'b1;
                ccount_d = ccount_q + ONE;
              end
              chain_d = 2'd0;
            end
          endcase
        end else begin
          ev_seq    = 1'b1;
          phase_d   = code_ph;
          dwell_d   = ONE;
          partial_d = 1'b1;
          chain_d   = 2'd0;
        end
      end
      default: state_d = SYNC;
    endcase

    ev_any   = ev_ill | ev_seq | ev_dwell;
    ill_d    = ill_q | ev_ill;
    seq_d    = seq_q | ev_seq;
    dw_d     = dw_q | ev_dwell;
    pulse_d  = ev_any;
    ecount_d = (ev_any && (ecount_q != SAT)) ? ecount_q + ONE : ecount_q;
  end

  // Outputs come straight from registers: one-edge latency, no combinational path from light.
  always_comb begin
    mon.phase        = phase_q;
    mon.phase_valid  = (state_q == TRACK);
    mon.dwell        = dwell_q;
    mon.last_dwell   = last_q;
    mon.cycle_done   = done_q;
    mon.cycle_count  = ccount_q;
    mon.err_illegal  = ill_q;
    mon.err_sequence = seq_q;
    mon.err_dwell    = dw_q;
    mon.err_pulse    = pulse_q;
    mon.err_count    = ecount_q;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed vector bench for traffic_light_monitor
// dut_a runs MIN=1/MAX=254, dut_b runs MIN=2/MAX=4; both see the same light and reset.
module tb_traffic_light_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] light;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_light_monitor_if #(.CNT_W(8)) ifa ();
  traffic_light_monitor_if #(.CNT_W(8)) ifb ();

  assign ifa.light = light;
  assign ifb.light = light;

  traffic_light_monitor #(.CNT_W(8), .MIN_DWELL(1), .MAX_DWELL(254)) dut_a (
    .clk (clk),
    .rst (rst),
    .mon (ifa)
  );

  traffic_light_monitor #(.CNT_W(8), .MIN_DWELL(2), .MAX_DWELL(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .mon (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] light;
    logic [1:0] ph;
    logic       v;
    logic [7:0] d;
    logic [7:0] last;
    logic       done;
    logic [7:0] cc;
    logic [2:0] errs;   // {illegal, sequence, dwell}
    logic       pulse;
    logic [7:0] ec;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  localparam logic [39:0] RESET_A = {2'd3, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};

  function automatic logic [39:0] pack_a();
    return {ifa.phase, ifa.phase_valid, ifa.dwell, ifa.last_dwell, ifa.cycle_done,
            ifa.cycle_count, ifa.err_illegal, ifa.err_sequence, ifa.err_dwell,
            ifa.err_pulse, ifa.err_count};
  endfunction

  function automatic logic [39:0] pack_vec(input vec_t x);
    return {x.ph, x.v, x.d, x.last, x.done, x.cc, x.errs, x.pulse, x.ec};
  endfunction

  task automatic step(input logic r, input logic [2:0] l);
    rst   = r;
    light = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int pulses;
    logic [7:0] dwell_at_pulse;
    logic dw_before;

    rst   = 1'b1;
    light = 3'b000;

    // rst light ph v d last done cc errs pulse ec
    vecs[0]  = '{1'b1, 3'b010, 2'd3, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 3'b111, 2'd3, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd1, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 3'b001, 2'd1, 1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 3'b100, 2'd2, 1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd1, 8'd1, 1'b1, 8'd1, 3'b000, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 3'b001, 2'd1, 1'b1, 8'd1, 8'd1, 1'b0, 8'd1, 3'b000, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 3'b100, 2'd2, 1'b1, 8'd1, 8'd1, 1'b0, 8'd1, 3'b000, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd1, 8'd1, 1'b1, 8'd2, 3'b000, 1'b0, 8'd0};
    // G x2 then R: out of order, resync with chain cleared
    vecs[9]  = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd2, 8'd1, 1'b0, 8'd2, 3'b000, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 3'b100, 2'd2, 1'b1, 8'd1, 8'd1, 1'b0, 8'd2, 3'b010, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 3'b100, 2'd2, 1'b1, 8'd2, 8'd1, 1'b0, 8'd2, 3'b010, 1'b0, 8'd1};
    vecs[12] = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd1, 8'd2, 1'b0, 8'd2, 3'b010, 1'b0, 8'd1};
    // Reset, invalid code straight out of reset is silent, then illegal mid-GREEN
    vecs[13] = '{1'b1, 3'b010, 2'd3, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[14] = '{1'b0, 3'b000, 2'd3, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[15] = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd1, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[16] = '{1'b0, 3'b010, 2'd0, 1'b1, 8'd2, 8'd0, 1'b0, 8'd0, 3'b000, 1'b0, 8'd0};
    vecs[17] = '{1'b0, 3'b110, 2'd3, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 3'b100, 1'b1, 8'd1};
    vecs[18] = '{1'b0, 3'b001, 2'd1, 1'b1, 8'd1, 8'd0, 1'b0, 8'd0, 3'b100, 1'b0, 8'd1};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].light);
      check($sformatf("vec%0d", i), pack_a(), pack_vec(vecs[i]));
    end

    // dut_b: G x3, Y x1, R x5 with MIN=2, MAX=4
    step(1'b1, 3'b010);
    for (int k = 0; k < 3; k++) step(1'b0, 3'b010);
    check("b_g_dwell", {32'd0, ifb.dwell}, {32'd0, 8'd3});
    step(1'b0, 3'b001);
    check("b_y_noerr", {38'd0, ifb.err_dwell, ifb.err_pulse}, 40'd0);
    step(1'b0, 3'b100);
    check("b_min_viol", {22'd0, ifb.err_dwell, ifb.err_pulse, ifb.err_count, ifb.last_dwell},
          {22'd0, 1'b1, 1'b1, 8'd1, 8'd1});
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 3'b100);
      check($sformatf("b_r%0d_pulse", k), {39'd0, ifb.err_pulse}, {39'd0, (k == 5)});
    end
    check("b_final", {22'd0, ifb.phase, ifb.err_count, ifb.dwell}, {22'd0, 2'd2, 8'd2, 8'd5});

    // dut_a has been in a chain G,Y,R; finish it and add four more cycles for cycle_count=5
    step(1'b0, 3'b010);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 3'b001);
      step(1'b0, 3'b100);
      step(1'b0, 3'b010);
    end
    step(1'b0, 3'b111);
    check("a_pre_reset", {30'd0, ifa.cycle_count, ifa.err_illegal, ifa.err_pulse},
          {30'd0, 8'd5, 1'b1, 1'b1});

    step(1'b1, 3'b010);
    check("rst_hold1", pack_a(), RESET_A);
    step(1'b1, 3'b111);
    check("rst_hold2", pack_a(), RESET_A);
    step(1'b1, 3'b001);
    check("rst_hold3", pack_a(), RESET_A);

    step(1'b0, 3'b010);
    step(1'b0, 3'b001);
    step(1'b0, 3'b100);
    check("fresh_no_done", {31'd0, ifa.cycle_done, ifa.cycle_count}, 40'd0);
    step(1'b0, 3'b010);
    check("fresh_cycle", {31'd0, ifa.cycle_done, ifa.cycle_count}, {31'd0, 1'b1, 8'd1});

    // Hold GREEN 300 cycles on dut_a: one MAX violation at dwell 255, then saturation
    step(1'b1, 3'b010);
    pulses         = 0;
    dwell_at_pulse = 8'd0;
    dw_before      = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 3'b010);
      if (ifa.err_pulse) begin
        pulses++;
        dwell_at_pulse = ifa.dwell;
      end
      if (k == 254) dw_before = ifa.err_dwell;
    end
    check("max_not_early", {39'd0, dw_before}, 40'd0);
    check("max_pulses", {8'd0, 32'(pulses)}, {8'd0, 32'd1});
    check("max_at_255", {32'd0, dwell_at_pulse}, {32'd0, 8'd255});
    check("max_final", {21'd0, ifa.phase, ifa.err_dwell, ifa.dwell, ifa.err_count},
          {21'd0, 2'd0, 1'b1, 8'd255, 8'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
